// File: rtl/modport_slave_if.sv
// AXI4 bus bundle shared by the VIP master agent and the modport_slave endpoint.
// The master modport drives addresses, write data and the ready signals of the
// response channels. The slave modport drives the accept signals and the responses.
interface modport_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [LEN_WIDTH-1:0]  AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [LEN_WIDTH-1:0]  ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/modport_slave.sv
// AXI4 slave endpoint backed by a word-addressed memory. Independent write and
// read FSMs, one outstanding transaction each; FIXED/INCR/WRAP bursts.
// Optional feature macro: MODPORT_OOR_SLVERR_EN -- when defined, beats whose byte
// address lies beyond the memory give SLVERR, drop writes and read back zero;
// otherwise addresses wrap modulo the memory size with an OKAY response.
module modport_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input logic         ACLK,
  input logic         ARESET,
  modport_slave_if.slave s
);
  localparam int STRB   = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB);
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef MODPORT_OOR_SLVERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address of the beat after 'a'; WRAP stays inside an aligned (len+1)*step window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
    input logic [LEN_WIDTH-1:0] len, input logic [1:0] burst);
    logic [2:0]            sz;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wmask;
    logic                  wrap_ok;
    sz      = (size > 3'(LSB)) ? 3'(LSB) : size;
    step    = ADDR_WIDTH'(1) << sz;
    wmask   = (ADDR_WIDTH'(len) << sz) | (step - ADDR_WIDTH'(1));
    wrap_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
              (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    if (burst == 2'b00)
      next_addr = a;
    else if (burst == 2'b10 && wrap_ok)
      next_addr = (a & ~wmask) | ((a + step) & wmask);
    else
      next_addr = a + step;
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_AW'(a >> LSB);
  endfunction

  function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
    return OOR_EN && ({1'b0, a} >= MEM_BYTES);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
    return oor(a) ? '0 : mem[word_idx(a)];
  endfunction

  function automatic logic [1:0] rd_resp(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] burst);
    return (burst == 2'b11 || oor(a)) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  // Write path state
  wstate_t               wstate;
  logic                  awready, wready, bvalid, w_err;
  logic [ID_WIDTH-1:0]   bid, w_id;
  logic [1:0]            bresp, w_burst;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LEN_WIDTH-1:0]  w_len, w_cnt;
  logic [2:0]            w_size;
  logic                  w_last, w_beat_err;

  // Read path state
  rstate_t               rstate;
  logic                  arready, rvalid, rlast;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp, r_burst;
  logic [ADDR_WIDTH-1:0] r_addr, r_nxt;
  logic [LEN_WIDTH-1:0]  r_len, r_cnt;
  logic [2:0]            r_size;

  assign w_last     = (w_cnt == w_len);
  assign w_beat_err = (s.WLAST != w_last) || oor(w_addr);
  assign r_nxt      = next_addr(r_addr, r_size, r_len, r_burst);

  assign s.AWREADY = awready;
  assign s.WREADY  = wready;
  assign s.BVALID  = bvalid;
  assign s.BID     = bid;
  assign s.BRESP   = bresp;
  assign s.ARREADY = arready;
  assign s.RVALID  = rvalid;
  assign s.RLAST   = rlast;
  assign s.RID     = rid;
  assign s.RDATA   = rdata;
  assign s.RRESP   = rresp;

  // Write FSM: accept AW, count beats to AWLEN+1, then hold B until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (s.AWVALID) begin
          w_id    <= s.AWID;
          w_addr  <= s.AWADDR;
          w_len   <= s.AWLEN;
          w_size  <= s.AWSIZE;
          w_burst <= s.AWBURST;
          w_cnt   <= '0;
          w_err   <= (s.AWBURST == 2'b11);
          awready <= 1'b0;
          wready  <= 1'b1;
          wstate  <= W_DATA;
        end
        W_DATA: if (s.WVALID) begin
          w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
          w_cnt  <= w_cnt + LEN_WIDTH'(1);
          w_err  <= w_err | w_beat_err;
          if (w_last) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bid    <= w_id;
            bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            wstate <= W_RESP;
          end
        end
        W_RESP: if (s.BREADY) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wstate  <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Memory byte-lane writes for each accepted in-range W beat.
  always_ff @(posedge ACLK) begin
    if (wstate == W_DATA && s.WVALID && !oor(w_addr)) begin
      for (int i = 0; i < STRB; i++) begin
        if (s.WSTRB[i]) mem[word_idx(w_addr)][8*i +: 8] <= s.WDATA[8*i +: 8];
      end
    end
  end

  // Read FSM: accept AR, present one beat at a time, advance on each R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate  <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (s.ARVALID) begin
          r_addr  <= s.ARADDR;
          r_len   <= s.ARLEN;
          r_size  <= s.ARSIZE;
          r_burst <= s.ARBURST;
          r_cnt   <= '0;
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rid     <= s.ARID;
          rdata   <= rd_word(s.ARADDR);
          rresp   <= rd_resp(s.ARADDR, s.ARBURST);
          rlast   <= (s.ARLEN == '0);
          rstate  <= R_DATA;
        end
        R_DATA: if (s.RREADY) begin
          if (r_cnt == r_len) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end else begin
            r_addr <= r_nxt;
            r_cnt  <= r_cnt + LEN_WIDTH'(1);
            rdata  <= rd_word(r_nxt);
            rresp  <= rd_resp(r_nxt, r_burst);
            rlast  <= ((r_cnt + LEN_WIDTH'(1)) == r_len);
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modport_slave.sv
// Directed bench for modport_slave: drives the master side of the bus with
// hand-written bursts and checks every response against precomputed values.
module tb_modport_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8)) bus ();

  modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8),
                  .MEM_DEPTH(1024)) dut (.ACLK(clk), .ARESET(rst), .s(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed=no handshake expected=handshake within 50 cycles", tag);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    while (!bus.AWREADY && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.AWREADY) timeout("aw_wait");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int k = 0;
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    while (!bus.WREADY && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.WREADY) timeout("w_wait");
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
  endtask

  task automatic recv_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int k = 0;
    bus.BREADY = 1'b1;
    while (!bus.BVALID && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.BVALID) timeout({tag, "_bwait"});
    else begin
      check({tag, "_bid"}, 64'(bus.BID), 64'(id));
      check({tag, "_bresp"}, 64'(bus.BRESP), 64'(resp));
    end
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k = 0;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.ARREADY) timeout("ar_wait");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic recv_r(input string tag, input logic [3:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
    int k = 0;
    bus.RREADY = 1'b1;
    while (!bus.RVALID && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.RVALID) timeout({tag, "_rwait"});
    else begin
      check({tag, "_rid"}, 64'(bus.RID), 64'(id));
      check({tag, "_rdata"}, 64'(bus.RDATA), 64'(data));
      check({tag, "_rresp"}, 64'(bus.RRESP), 64'(resp));
      check({tag, "_rlast"}, 64'(bus.RLAST), 64'(last));
    end
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, 64'(bus.AWREADY), 64'd1);
    check({tag, "_arready"}, 64'(bus.ARREADY), 64'd1);
    check({tag, "_wready"}, 64'(bus.WREADY), 64'd0);
    check({tag, "_bvalid"}, 64'(bus.BVALID), 64'd0);
    check({tag, "_rvalid"}, 64'(bus.RVALID), 64'd0);
    check({tag, "_rlast"}, 64'(bus.RLAST), 64'd0);
    check({tag, "_bid_bresp"}, 64'({bus.BID, bus.BRESP}), 64'd0);
    check({tag, "_rid_rdata_rresp"}, 64'({bus.RID, bus.RDATA, bus.RRESP}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR write of four words at 0x10, then read them back
    send_aw(4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
    check("incr_wready_lat", 64'(bus.WREADY), 64'd1);
    check("incr_awready_low", 64'(bus.AWREADY), 64'd0);
    send_w(32'hA0, 4'hF, 1'b0);
    send_w(32'hA1, 4'hF, 1'b0);
    send_w(32'hA2, 4'hF, 1'b0);
    send_w(32'hA3, 4'hF, 1'b1);
    check("incr_bvalid_lat", 64'(bus.BVALID), 64'd1);
    check("incr_wready_drop", 64'(bus.WREADY), 64'd0);
    recv_b("incr_b", 4'd5, 2'b00);
    check("incr_awready_back", 64'(bus.AWREADY), 64'd1);

    send_ar(4'd3, 32'h10, 8'd3, 3'd2, 2'b01);
    check("incr_rvalid_lat", 64'(bus.RVALID), 64'd1);
    recv_r("incr_r0", 4'd3, 32'hA0, 2'b00, 1'b0);
    recv_r("incr_r1", 4'd3, 32'hA1, 2'b00, 1'b0);
    recv_r("incr_r2", 4'd3, 32'hA2, 2'b00, 1'b0);
    recv_r("incr_r3", 4'd3, 32'hA3, 2'b00, 1'b1);
    check("incr_rvalid_end", 64'(bus.RVALID), 64'd0);
    check("incr_arready_end", 64'(bus.ARREADY), 64'd1);

    // Byte strobes merge into the existing word
    send_aw(4'd1, 32'h40, 8'd0, 3'd2, 2'b01);
    send_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    recv_b("strb_b0", 4'd1, 2'b00);
    send_aw(4'd1, 32'h40, 8'd0, 3'd2, 2'b01);
    send_w(32'h1234_5678, 4'b0101, 1'b1);
    recv_b("strb_b1", 4'd1, 2'b00);
    send_ar(4'd2, 32'h40, 8'd0, 3'd2, 2'b01);
    recv_r("strb_r", 4'd2, 32'hFF34_FF78, 2'b00, 1'b1);

    // WRAP read from mid-window, then a FIXED read of one word
    send_aw(4'd6, 32'h20, 8'd3, 3'd2, 2'b01);
    send_w(32'd0, 4'hF, 1'b0);
    send_w(32'd1, 4'hF, 1'b0);
    send_w(32'd2, 4'hF, 1'b0);
    send_w(32'd3, 4'hF, 1'b1);
    recv_b("wrap_b", 4'd6, 2'b00);
    send_ar(4'd7, 32'h28, 8'd3, 3'd2, 2'b10);
    recv_r("wrap_r0", 4'd7, 32'd2, 2'b00, 1'b0);
    recv_r("wrap_r1", 4'd7, 32'd3, 2'b00, 1'b0);
    recv_r("wrap_r2", 4'd7, 32'd0, 2'b00, 1'b0);
    recv_r("wrap_r3", 4'd7, 32'd1, 2'b00, 1'b1);
    send_ar(4'd8, 32'h20, 8'd2, 3'd2, 2'b00);
    recv_r("fixed_r0", 4'd8, 32'd0, 2'b00, 1'b0);
    recv_r("fixed_r1", 4'd8, 32'd0, 2'b00, 1'b0);
    recv_r("fixed_r2", 4'd8, 32'd0, 2'b00, 1'b1);

    // R backpressure mid-burst holds the beat stable
    send_ar(4'd9, 32'h10, 8'd3, 3'd2, 2'b01);
    recv_r("bp_r0", 4'd9, 32'hA0, 2'b00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_rvalid", 64'(bus.RVALID), 64'd1);
      check("bp_hold_rdata", 64'(bus.RDATA), 64'hA1);
      check("bp_hold_rlast", 64'(bus.RLAST), 64'd0);
    end
    recv_r("bp_r1", 4'd9, 32'hA1, 2'b00, 1'b0);
    recv_r("bp_r2", 4'd9, 32'hA2, 2'b00, 1'b0);
    recv_r("bp_r3", 4'd9, 32'hA3, 2'b00, 1'b1);

    // B backpressure keeps BVALID high
    send_aw(4'd4, 32'h50, 8'd0, 3'd2, 2'b01);
    send_w(32'h55, 4'hF, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("bp_hold_bvalid", 64'(bus.BVALID), 64'd1);
    end
    recv_b("bp_b", 4'd4, 2'b00);

    // Early WLAST: the burst still runs four beats and ends in SLVERR
    send_aw(4'd2, 32'h60, 8'd3, 3'd2, 2'b01);
    send_w(32'd11, 4'hF, 1'b0);
    send_w(32'd12, 4'hF, 1'b1);
    check("wlast_no_early_b", 64'(bus.BVALID), 64'd0);
    check("wlast_wready_kept", 64'(bus.WREADY), 64'd1);
    send_w(32'd13, 4'hF, 1'b0);
    send_w(32'd14, 4'hF, 1'b1);
    recv_b("wlast_err_b", 4'd2, 2'b10);

    // Reserved burst type answers SLVERR on both paths
    send_aw(4'd3, 32'h70, 8'd0, 3'd2, 2'b11);
    send_w(32'd7, 4'hF, 1'b1);
    recv_b("burst11_b", 4'd3, 2'b10);
    send_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'b11);
    recv_r("burst11_r", 4'd3, 32'hA0, 2'b10, 1'b1);

    // Reset in the middle of both bursts
    send_aw(4'd9, 32'h80, 8'd3, 3'd2, 2'b01);
    send_w(32'd99, 4'hF, 1'b0);
    send_ar(4'd4, 32'h10, 8'd3, 3'd2, 2'b01);
    check("midrst_pre_rvalid", 64'(bus.RVALID), 64'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_rel_awready", 64'(bus.AWREADY), 64'd1);
    check("midrst_rel_arready", 64'(bus.ARREADY), 64'd1);
    check("midrst_rel_bvalid", 64'(bus.BVALID), 64'd0);

`ifdef MODPORT_OOR_SLVERR_EN
    send_aw(4'd1, 32'h10000, 8'd0, 3'd2, 2'b01);
    send_w(32'hDEAD, 4'hF, 1'b1);
    recv_b("oor_b", 4'd1, 2'b10);
    send_ar(4'd1, 32'h10000, 8'd0, 3'd2, 2'b01);
    recv_r("oor_r", 4'd1, 32'd0, 2'b10, 1'b1);
`else
    send_aw(4'd1, 32'h10000, 8'd0, 3'd2, 2'b01);
    send_w(32'h77, 4'hF, 1'b1);
    recv_b("alias_b", 4'd1, 2'b00);
    send_ar(4'd1, 32'h0, 8'd0, 3'd2, 2'b01);
    recv_r("alias_r", 4'd1, 32'h77, 2'b00, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
